// File: rtl/ldst_mem_queue.sv
// ldst_mem_queue: in-order buffer between the LDST address stage and the lane
// memory port. Packets are queued, issued one at a time over valid/ready,
// with at most one load outstanding. Load data is aligned and sign-extended
// before being written back to the register file.
module ldst_mem_queue #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 6,
    parameter int SPACE_W = 2,
    parameter int SIZE_W  = 2,
    parameter int DEPTH   = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          ldstPacketLaneValid_i,
    input  logic [ADDR_W+REG_W+DATA_W+SPACE_W+SIZE_W-1:0] ldstPacketLane_i,
    input  logic                                          ldstIsLoad_i,
    output logic                                          ldstReady_o,
    output logic                                          memReqValid_o,
    input  logic                                          memReqReady_i,
    output logic                                          memReqWe_o,
    output logic [ADDR_W-1:0]                             memReqAddr_o,
    output logic [DATA_W-1:0]                             memReqWdata_o,
    output logic [3:0]                                    memReqBe_o,
    output logic [SPACE_W-1:0]                            memReqSpace_o,
    input  logic                                          memRspValid_i,
    input  logic [DATA_W-1:0]                             memRspData_i,
    output logic                                          wbValid_o,
    output logic [REG_W-1:0]                              wbReg_o,
    output logic [DATA_W-1:0]                             wbData_o,
    output logic                                          misalign_o
);

    localparam int PKT_W   = ADDR_W + REG_W + DATA_W + SPACE_W + SIZE_W;
    localparam int ENTRY_W = PKT_W + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

    // Alignment rule: bytes never fault, halves need an even address, words
    // (and the reserved size, handled as a word) need a 4-byte boundary.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            default:   bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    // Byte enables for a store of the given size at the given word offset.
    function automatic logic [3:0] storeBe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = 4'b0011 << off;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all byte lanes so the memory can pick
    // any lane using the byte enables alone.
    function automatic logic [DATA_W-1:0] storeWdata(input logic [1:0] size,
                                                     input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] w;
        case (size)
            SIZE_BYTE: w = {4{data[7:0]}};
            SIZE_HALF: w = {2{data[15:0]}};
            default:   w = data;
        endcase
        return w;
    endfunction

    // Extract the addressed byte/half from the raw word and sign-extend.
    function automatic logic [DATA_W-1:0] loadFormat(input logic [1:0] size,
                                                     input logic [1:0] off,
                                                     input logic [DATA_W-1:0] raw);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (off)
            2'b00:   b = raw[7:0];
            2'b01:   b = raw[15:8];
            2'b10:   b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = off[1] ? raw[31:16] : raw[15:0];
        case (size)
            SIZE_BYTE: r = {{24{b[7]}}, b};
            SIZE_HALF: r = {{16{h[15]}}, h};
            default:   r = raw;
        endcase
        return r;
    endfunction

    logic [ENTRY_W-1:0] fifoMem_r [DEPTH];
    logic [PTR_W-1:0]   wrPtr_r;
    logic [PTR_W-1:0]   rdPtr_r;
    logic [CNT_W-1:0]   count_r;
    state_t             state_r;
    logic [REG_W-1:0]   savedReg_r;
    logic [1:0]         savedOff_r;
    logic [1:0]         savedSize_r;

    logic               pushEn_s;
    logic               popEn_s;
    logic [ENTRY_W-1:0] head_s;
    logic               headIsLoad_s;
    logic [ADDR_W-1:0]  headAddr_s;
    logic [REG_W-1:0]   headReg_s;
    logic [DATA_W-1:0]  headData_s;
    logic [SPACE_W-1:0] headSpace_s;
    logic [1:0]         headSize_s;
    logic [1:0]         headOff_s;

    assign ldstReady_o  = (count_r != FULL_CNT);
    assign pushEn_s     = ldstPacketLaneValid_i && ldstReady_o;
    assign popEn_s      = (state_r == IDLE) && (count_r != {CNT_W{1'b0}});

    assign head_s       = fifoMem_r[rdPtr_r];
    assign headIsLoad_s = head_s[PKT_W];
    assign headAddr_s   = head_s[PKT_W-1 -: ADDR_W];
    assign headReg_s    = head_s[REG_W+DATA_W+SPACE_W+SIZE_W-1 -: REG_W];
    assign headData_s   = head_s[DATA_W+SPACE_W+SIZE_W-1 -: DATA_W];
    assign headSpace_s  = head_s[SPACE_W+SIZE_W-1 -: SPACE_W];
    assign headSize_s   = head_s[1:0];
    assign headOff_s    = headAddr_s[1:0];

    // FIFO storage and pointer/count bookkeeping; push and pop may coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifoMem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            if (pushEn_s) begin
                fifoMem_r[wrPtr_r] <= {ldstIsLoad_i, ldstPacketLane_i};
                wrPtr_r            <= wrPtr_r + 1'b1;
            end
            if (popEn_s) begin
                rdPtr_r <= rdPtr_r + 1'b1;
            end
            case ({pushEn_s, popEn_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM: pop into request registers, handshake, await load data, write back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            memReqValid_o <= 1'b0;
            memReqWe_o    <= 1'b0;
            memReqAddr_o  <= {ADDR_W{1'b0}};
            memReqWdata_o <= {DATA_W{1'b0}};
            memReqBe_o    <= 4'b0000;
            memReqSpace_o <= {SPACE_W{1'b0}};
            wbValid_o     <= 1'b0;
            wbReg_o       <= {REG_W{1'b0}};
            wbData_o      <= {DATA_W{1'b0}};
            misalign_o    <= 1'b0;
            savedReg_r    <= {REG_W{1'b0}};
            savedOff_r    <= 2'b00;
            savedSize_r   <= 2'b00;
        end else begin
            wbValid_o  <= 1'b0;
            misalign_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (popEn_s) begin
                        if (isMisaligned(headSize_s, headOff_s)) begin
                            misalign_o <= 1'b1;
                        end else begin
                            memReqValid_o <= 1'b1;
                            memReqWe_o    <= ~headIsLoad_s;
                            memReqAddr_o  <= {headAddr_s[ADDR_W-1:2], 2'b00};
                            memReqSpace_o <= headSpace_s;
                            memReqWdata_o <= headIsLoad_s ? {DATA_W{1'b0}}
                                                          : storeWdata(headSize_s, headData_s);
                            memReqBe_o    <= headIsLoad_s ? 4'b1111
                                                          : storeBe(headSize_s, headOff_s);
                            savedReg_r    <= headReg_s;
                            savedOff_r    <= headOff_s;
                            savedSize_r   <= headSize_s;
                            state_r       <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Request fields stay frozen until the port accepts.
                    if (memReqReady_i) begin
                        memReqValid_o <= 1'b0;
                        state_r       <= memReqWe_o ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (memRspValid_i) begin
                        wbValid_o <= 1'b1;
                        wbReg_o   <= savedReg_r;
                        wbData_o  <= loadFormat(savedSize_r, savedOff_r, memRspData_i);
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    memReqValid_o <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldst_mem_queue.sv
// Self-checking bench for ldst_mem_queue: directed scenarios plus a randomized
// run scored against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_ldst_mem_queue;

    localparam int PKT_W = 32 + 6 + 32 + 2 + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ldstPacketLaneValid_i = 1'b0;
    logic [PKT_W-1:0] ldstPacketLane_i = '0;
    logic             ldstIsLoad_i = 1'b0;
    logic             ldstReady_o;
    logic             memReqValid_o;
    logic             memReqReady_i = 1'b0;
    logic             memReqWe_o;
    logic [31:0]      memReqAddr_o;
    logic [31:0]      memReqWdata_o;
    logic [3:0]       memReqBe_o;
    logic [1:0]       memReqSpace_o;
    logic             memRspValid_i = 1'b0;
    logic [31:0]      memRspData_i = '0;
    logic             wbValid_o;
    logic [5:0]       wbReg_o;
    logic [31:0]      wbData_o;
    logic             misalign_o;

    ldst_mem_queue dut (
        .clk                   (clk),
        .reset                 (reset),
        .ldstPacketLaneValid_i (ldstPacketLaneValid_i),
        .ldstPacketLane_i      (ldstPacketLane_i),
        .ldstIsLoad_i          (ldstIsLoad_i),
        .ldstReady_o           (ldstReady_o),
        .memReqValid_o         (memReqValid_o),
        .memReqReady_i         (memReqReady_i),
        .memReqWe_o            (memReqWe_o),
        .memReqAddr_o          (memReqAddr_o),
        .memReqWdata_o         (memReqWdata_o),
        .memReqBe_o            (memReqBe_o),
        .memReqSpace_o         (memReqSpace_o),
        .memRspValid_i         (memRspValid_i),
        .memRspData_i          (memRspData_i),
        .wbValid_o             (wbValid_o),
        .wbReg_o               (wbReg_o),
        .wbData_o              (wbData_o),
        .misalign_o            (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  space;
    } req_t;

    typedef struct packed {
        logic [5:0]  rg;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic [5:0] rg;
        logic [1:0] sz;
        logic [1:0] off;
    } ld_t;

    req_t reqQ[$];
    wb_t  wbQ[$];
    int   misCnt = 0;
    int   validCycles = 0;
    int   checks = 0;
    int   passed = 0;

    // Observe the memory port and writeback on the falling edge.
    always @(negedge clk) begin
        req_t r;
        wb_t  w;
        if (memReqValid_o) validCycles++;
        if (memReqValid_o && memReqReady_i) begin
            r.we = memReqWe_o; r.addr = memReqAddr_o; r.wdata = memReqWdata_o;
            r.be = memReqBe_o; r.space = memReqSpace_o;
            reqQ.push_back(r);
        end
        if (wbValid_o) begin
            w.rg = wbReg_o; w.data = wbData_o;
            wbQ.push_back(w);
        end
        if (misalign_o) misCnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference rules ----------------
    function automatic bit refMis(input logic [1:0] sz, input int off);
        if (sz == 2'b10) return 1'b0;
        if (sz == 2'b01) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [3:0] refBe(input logic [1:0] sz, input int off);
        int v;
        if (sz == 2'b10) v = 1 << off;
        else if (sz == 2'b01) v = 3 << off;
        else v = 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] refWdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b10) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] sz, input int off, input logic [31:0] raw);
        logic [31:0] v;
        if (sz == 2'b10) begin
            v = (raw >> (8 * off)) & 32'hFF;
            if (v >= 32'd128) v = v | 32'hFFFFFF00;
            return v;
        end
        if (sz == 2'b01) begin
            v = (raw >> (8 * off)) & 32'hFFFF;
            if (v >= 32'd32768) v = v | 32'hFFFF0000;
            return v;
        end
        return raw;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMon();
        reqQ.delete();
        wbQ.delete();
        misCnt = 0;
        validCycles = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [5:0] rg, input logic [31:0] d,
                        input logic [1:0] sp, input logic [1:0] sz, input logic isLd);
        int budget;
        ldstPacketLane_i      = {a, rg, d, sp, sz};
        ldstIsLoad_i          = isLd;
        ldstPacketLaneValid_i = 1'b1;
        budget = 0;
        while (!ldstReady_o && budget < 200) begin
            tick();
            budget++;
        end
        if (!ldstReady_o) begin
            checks++;
            $display("FAIL push_timeout: ldstReady_o stayed %0b, required 1", ldstReady_o);
        end
        tick();
        ldstPacketLaneValid_i = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        ldstPacketLaneValid_i = 1'b0;
        memReqReady_i = 1'b0;
        memRspValid_i = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({memReqValid_o, wbValid_o, misalign_o, memReqWe_o} !== 4'b0000)
            $display("FAIL reset_pulses: got %b, required 0000", {memReqValid_o, wbValid_o, misalign_o, memReqWe_o});
        else passed++;
        checks++;
        if ({memReqAddr_o, memReqWdata_o, memReqBe_o, memReqSpace_o} !== 70'd0)
            $display("FAIL reset_req_data: got %h, required 0", {memReqAddr_o, memReqWdata_o, memReqBe_o, memReqSpace_o});
        else passed++;
        checks++;
        if ({wbReg_o, wbData_o} !== 38'd0)
            $display("FAIL reset_wb_data: got %h, required 0", {wbReg_o, wbData_o});
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if (ldstReady_o !== 1'b1) $display("FAIL reset_ready: got %b, required 1", ldstReady_o);
        else passed++;
    endtask

    task automatic doLoad(input string nm, input logic [31:0] a, input logic [5:0] rg,
                          input logic [1:0] sz, input logic [31:0] raw, input logic [31:0] expData);
        clearMon();
        memReqReady_i = 1'b1;
        push(a, rg, 32'h0, 2'b01, sz, 1'b1);
        checks++;
        if (memReqValid_o !== 1'b0) $display("FAIL %s_latency0: memReqValid_o got %b, required 0", nm, memReqValid_o);
        else passed++;
        tick();
        checks++;
        if (memReqValid_o !== 1'b1) $display("FAIL %s_latency1: memReqValid_o got %b, required 1", nm, memReqValid_o);
        else passed++;
        tick();
        checks++;
        if (reqQ.size() !== 1) $display("FAIL %s_req_count: got %0d, required 1", nm, reqQ.size());
        else passed++;
        if (reqQ.size() >= 1) begin
            checks++;
            if (reqQ[0].addr !== (a & 32'hFFFFFFFC) || reqQ[0].we !== 1'b0 || reqQ[0].be !== 4'hF || reqQ[0].space !== 2'b01)
                $display("FAIL %s_req: got addr=%h we=%b be=%h sp=%b, required addr=%h we=0 be=f sp=01",
                         nm, reqQ[0].addr, reqQ[0].we, reqQ[0].be, reqQ[0].space, a & 32'hFFFFFFFC);
            else passed++;
        end
        tick();
        memRspValid_i = 1'b1;
        memRspData_i  = raw;
        tick();
        memRspValid_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (wbQ.size() !== 1 || validCycles !== 1)
            $display("FAIL %s_wb_count: wb=%0d validCycles=%0d, required 1 and 1", nm, wbQ.size(), validCycles);
        else passed++;
        if (wbQ.size() >= 1) begin
            checks++;
            if (wbQ[0].rg !== rg || wbQ[0].data !== expData)
                $display("FAIL %s_wb: got reg=%0d data=%h, required reg=%0d data=%h", nm, wbQ[0].rg, wbQ[0].data, rg, expData);
            else passed++;
        end
    endtask

    task automatic test_loads();
        doLoad("word_load", 32'h100, 6'd5, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF);
        doLoad("half_load", 32'h42, 6'd9, 2'b01, 32'h80011234, 32'hFFFF8001);
        doLoad("byte_load", 32'h41, 6'd17, 2'b10, 32'h80011234, 32'h00000012);
        doLoad("byte_load_neg", 32'h43, 6'd33, 2'b10, 32'h80011234, 32'hFFFFFF80);
    endtask

    task automatic test_stores();
        clearMon();
        memReqReady_i = 1'b1;
        push(32'h203, 6'd1, 32'h000000A5, 2'b10, 2'b10, 1'b0);
        push(32'h202, 6'd2, 32'hCAFE1234, 2'b11, 2'b01, 1'b0);
        repeat (6) tick();
        checks++;
        if (reqQ.size() !== 2 || wbQ.size() !== 0)
            $display("FAIL store_count: reqs=%0d wbs=%0d, required 2 and 0", reqQ.size(), wbQ.size());
        else passed++;
        if (reqQ.size() >= 2) begin
            checks++;
            if (reqQ[0] !== {1'b1, 32'h200, 32'hA5A5A5A5, 4'b1000, 2'b10})
                $display("FAIL byte_store: got %h, required we=1 addr=200 wdata=a5a5a5a5 be=8 sp=2", reqQ[0]);
            else passed++;
            checks++;
            if (reqQ[1] !== {1'b1, 32'h200, 32'h12341234, 4'b1100, 2'b11})
                $display("FAIL half_store: got %h, required we=1 addr=200 wdata=12341234 be=c sp=3", reqQ[1]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int   idx;
        bit   accept;
        bit   haveSnap;
        bit   stableOk;
        req_t snap;
        req_t cur;
        clearMon();
        memReqReady_i = 1'b0;
        idx = 0; haveSnap = 1'b0; stableOk = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) begin
                ldstPacketLane_i      = {32'h300 + 32'(idx * 16), 6'd0, 32'h11110000 + 32'(idx), 2'b00, 2'b00};
                ldstIsLoad_i          = 1'b0;
                ldstPacketLaneValid_i = 1'b1;
            end else begin
                ldstPacketLaneValid_i = 1'b0;
            end
            accept = ldstReady_o && (idx < 6);
            tick();
            if (accept) idx++;
            cur = {memReqWe_o, memReqAddr_o, memReqWdata_o, memReqBe_o, memReqSpace_o};
            if (haveSnap) begin
                if (cur !== snap || memReqValid_o !== 1'b1) stableOk = 1'b0;
            end else if (memReqValid_o) begin
                snap = cur;
                haveSnap = 1'b1;
            end
        end
        checks++;
        if (idx !== 5) $display("FAIL bp_accepted: got %0d, required 5", idx);
        else passed++;
        checks++;
        if (ldstReady_o !== 1'b0) $display("FAIL bp_ready: got %b, required 0", ldstReady_o);
        else passed++;
        checks++;
        if (!haveSnap || !stableOk) $display("FAIL bp_stable: seen=%0b stable=%0b, required 1 and 1", haveSnap, stableOk);
        else passed++;
        ldstPacketLaneValid_i = 1'b0;
        memReqReady_i = 1'b1;
        for (int c = 0; c < 40 && reqQ.size() < 5; c++) tick();
        repeat (4) tick();
        checks++;
        if (reqQ.size() !== 5) $display("FAIL bp_drain_count: got %0d, required 5", reqQ.size());
        else passed++;
        for (int k = 0; k < 5 && k < reqQ.size(); k++) begin
            checks++;
            if (reqQ[k].addr !== 32'h300 + 32'(k * 16) || reqQ[k].wdata !== 32'h11110000 + 32'(k))
                $display("FAIL bp_order_%0d: got addr=%h wdata=%h, required addr=%h wdata=%h",
                         k, reqQ[k].addr, reqQ[k].wdata, 32'h300 + 32'(k * 16), 32'h11110000 + 32'(k));
            else passed++;
        end
    endtask

    task automatic test_misalign();
        clearMon();
        memReqReady_i = 1'b1;
        push(32'h102, 6'd3, 32'h12345678, 2'b00, 2'b00, 1'b0);
        repeat (4) tick();
        checks++;
        if (misCnt !== 1 || validCycles !== 0)
            $display("FAIL misalign_drop: pulses=%0d validCycles=%0d, required 1 and 0", misCnt, validCycles);
        else passed++;
        push(32'h104, 6'd3, 32'h87654321, 2'b00, 2'b00, 1'b0);
        repeat (4) tick();
        checks++;
        if (reqQ.size() !== 1 || misCnt !== 1)
            $display("FAIL misalign_follow_count: reqs=%0d pulses=%0d, required 1 and 1", reqQ.size(), misCnt);
        else passed++;
        if (reqQ.size() >= 1) begin
            checks++;
            if (reqQ[0].addr !== 32'h104 || reqQ[0].wdata !== 32'h87654321)
                $display("FAIL misalign_follow: got addr=%h wdata=%h, required 104 87654321", reqQ[0].addr, reqQ[0].wdata);
            else passed++;
        end
    endtask

    task automatic test_random();
        req_t expReqQ[$];
        ld_t  expLdQ[$];
        logic [31:0] rspQ[$];
        int   expMis;
        clearMon();
        expMis = 0;
        fork
            begin : driver
                for (int k = 0; k < 40; k++) begin
                    logic [31:0] a;
                    logic [31:0] d;
                    logic [1:0]  sz;
                    logic [1:0]  sp;
                    logic [5:0]  rg;
                    logic        isLd;
                    int          off;
                    req_t        e;
                    ld_t         l;
                    a = $urandom & 32'h0000FFFF;
                    d = $urandom;
                    sz = 2'($urandom_range(0, 3));
                    sp = 2'($urandom_range(0, 3));
                    rg = 6'($urandom_range(0, 63));
                    isLd = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) != 0) begin
                        if (sz == 2'b01) a = a & 32'hFFFFFFFE;
                        else if (sz != 2'b10) a = a & 32'hFFFFFFFC;
                    end
                    push(a, rg, d, sp, sz, isLd);
                    off = int'(a % 4);
                    if (refMis(sz, off)) begin
                        expMis++;
                    end else begin
                        e.we = !isLd;
                        e.addr = a - 32'(off);
                        e.wdata = isLd ? 32'h0 : refWdata(sz, d);
                        e.be = isLd ? 4'hF : refBe(sz, off);
                        e.space = sp;
                        expReqQ.push_back(e);
                        if (isLd) begin
                            l.rg = rg; l.sz = sz; l.off = 2'(off);
                            expLdQ.push_back(l);
                        end
                    end
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin : responder
                int pend;
                pend = -1;
                for (int c = 0; c < 1500; c++) begin
                    memRspValid_i = 1'b0;
                    if (pend == 0) begin
                        memRspValid_i = 1'b1;
                        memRspData_i  = $urandom;
                        rspQ.push_back(memRspData_i);
                        pend = -1;
                    end else if (pend > 0) begin
                        pend--;
                    end
                    memReqReady_i = 1'($urandom_range(0, 1));
                    if (memReqValid_o && memReqReady_i && !memReqWe_o) pend = $urandom_range(0, 3);
                    tick();
                end
                memRspValid_i = 1'b0;
            end
        join
        checks++;
        if (reqQ.size() !== expReqQ.size() || misCnt !== expMis)
            $display("FAIL rand_counts: reqs=%0d mis=%0d, required reqs=%0d mis=%0d", reqQ.size(), misCnt, expReqQ.size(), expMis);
        else passed++;
        for (int i = 0; i < reqQ.size() && i < expReqQ.size(); i++) begin
            req_t act;
            act = reqQ[i];
            if (!act.we) act.wdata = 32'h0;
            checks++;
            if (act !== expReqQ[i]) $display("FAIL rand_req_%0d: got %h, required %h", i, act, expReqQ[i]);
            else passed++;
        end
        checks++;
        if (wbQ.size() !== expLdQ.size() || rspQ.size() !== expLdQ.size())
            $display("FAIL rand_wb_count: wbs=%0d rsps=%0d, required %0d", wbQ.size(), rspQ.size(), expLdQ.size());
        else passed++;
        for (int i = 0; i < wbQ.size() && i < expLdQ.size() && i < rspQ.size(); i++) begin
            logic [31:0] ed;
            ed = refLoad(expLdQ[i].sz, int'(expLdQ[i].off), rspQ[i]);
            checks++;
            if (wbQ[i].rg !== expLdQ[i].rg || wbQ[i].data !== ed)
                $display("FAIL rand_wb_%0d: got reg=%0d data=%h, required reg=%0d data=%h", i, wbQ[i].rg, wbQ[i].data, expLdQ[i].rg, ed);
            else passed++;
        end
    endtask

    task automatic test_reset_in_wait();
        clearMon();
        memReqReady_i = 1'b1;
        push(32'h80, 6'd7, 32'h0, 2'b00, 2'b00, 1'b1);
        repeat (2) tick();
        push(32'h90, 6'd0, 32'h1, 2'b00, 2'b00, 1'b0);
        push(32'h94, 6'd0, 32'h2, 2'b00, 2'b00, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        checks++;
        if (memReqValid_o !== 1'b0 || ldstReady_o !== 1'b1)
            $display("FAIL rst_wait_during: valid=%b ready=%b, required 0 and 1", memReqValid_o, ldstReady_o);
        else passed++;
        reset = 1'b1;
        clearMon();
        memRspValid_i = 1'b1;
        memRspData_i  = 32'h55AA55AA;
        tick();
        memRspValid_i = 1'b0;
        repeat (6) tick();
        checks++;
        if (wbQ.size() !== 0 || reqQ.size() !== 0 || validCycles !== 0)
            $display("FAIL rst_wait_after: wbs=%0d reqs=%0d validCycles=%0d, required 0 0 0", wbQ.size(), reqQ.size(), validCycles);
        else passed++;
        checks++;
        if (ldstReady_o !== 1'b1) $display("FAIL rst_wait_ready: got %b, required 1", ldstReady_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_backpressure();
        applyReset();
        test_misalign();
        test_random();
        applyReset();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ldst_mem_queue.md
Name: ldst_mem_queue

Overview:
- Sits directly downstream of the per-lane LDST address-generation stage and consumes its lane packet {addr, loadReg, storeData, space, size} plus a load/store flag.
- Buffers packets in a small in-order FIFO and issues them one at a time to the lane memory port over a valid/ready handshake.
- Tracks a single outstanding load at a time.
- Formats returned load data by size and offset, and produces a register-file writeback.

Parameters:
- ADDR_W, 32, address width (SIZE_ADDR)
- DATA_W, 32, data width (SIZE_DATA); must be 32
- REG_W, 6, destination register field width (SIZE_REGFILE_BR)
- SPACE_W, 2, memory-space field width (LDST_SPACE_LOG)
- SIZE_W, 2, access-size field width (LDST_TYPES_LOG)
- DEPTH, 4, FIFO entries; power of two, >=2

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- ldstPacketLaneValid_i  in  1  input packet valid
- ldstPacketLane_i  in  ADDR_W+REG_W+DATA_W+SPACE_W+SIZE_W  packet {addr, loadReg, storeData, space, size}, MSB first
- ldstIsLoad_i  in  1  1 = load, 0 = store; qualified by valid
- ldstReady_o  out  1  queue can accept a packet this cycle
- memReqValid_o  out  1  memory request valid
- memReqReady_i  in  1  memory accepts request
- memReqWe_o  out  1  1 = store
- memReqAddr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
- memReqWdata_o  out  DATA_W  store data replicated to all byte lanes per size
- memReqBe_o  out  4  byte enables
- memReqSpace_o  out  SPACE_W  memory space, passed through
- memRspValid_i  in  1  load response valid (in order, only after accepted load)
- memRspData_i  in  DATA_W  raw 32-bit word
- wbValid_o  out  1  writeback valid, one-cycle pulse
- wbReg_o  out  REG_W  destination register
- wbData_o  out  DATA_W  formatted load data
- misalign_o  out  1  one-cycle pulse: request dropped as misaligned

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, count=0, FSM=IDLE. memReqValid_o, wbValid_o and misalign_o are 0. All data outputs are 0. ldstReady_o=1 once reset deasserts.
- ldstReady_o = (count != DEPTH), from registered count. Push when valid && ready. Packets offered while not ready are not captured; the source must hold them.
- FIFO has no bypass. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- size encoding: 00 = word, 01 = half, 10 = byte, 11 = reserved, treated as word.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into the request registers.
    - If the head is misaligned: pulse misalign_o, issue no request, stay IDLE.
    - Otherwise go to REQ with memReqValid_o=1.
    - Minimum latency: a packet pushed at edge t drives memReqValid_o=1 after edge t+1.
  - REQ: all memReq* outputs are held stable while memReqReady_i=0. On memReqValid_o && memReqReady_i:
    - store: go to IDLE.
    - load: go to WAIT; keep the register, offset and size.
    - memReqValid_o drops at that edge. The next request can be issued no earlier than the following IDLE pop, i.e. at most one request every 2 cycles.
  - WAIT: memReqValid_o=0. On memRspValid_i, at the next edge:
    - wbValid_o=1, wbReg_o = saved register, wbData_o = formatted data.
    - Go to IDLE.
    - wbValid_o is cleared after one cycle.
- Store formatting:
  - byte: wdata = {4{data[7:0]}}, be = 1<<addr[1:0].
  - half: wdata = {2{data[15:0]}}, be = 4'b0011<<addr[1:0].
  - word: wdata = data, be = 4'b1111.
  - memReqBe_o = 4'b1111 for loads.
- Load formatting: select the byte or half at offset addr[1:0] and sign-extend to 32 bits. Word passes through unchanged.
- memRspValid_i outside WAIT is ignored.
- memReqSpace_o is not interpreted; it is copied from the packet.
- Reset mid-operation clears everything; an in-flight load response after reset is ignored.

Test Plan:
- Word load: addr=0x100, reg=5, size=00, load; memReqReady_i=1, response 0xDEADBEEF 2 cycles later.
  -> memReqValid_o 1 cycle, Addr=0x100, We=0, Be=F; wbValid_o=1, wbReg_o=5, wbData_o=0xDEADBEEF exactly once.
- Byte store: addr=0x203, data=0x000000A5, size=10.
  -> Addr=0x200, Wdata=0xA5A5A5A5, Be=4'b1000, We=1; no writeback.
- Half load: addr=0x42, size=01, response 0x8001_1234.
  -> wbData_o=0xFFFF8001.
  - Same with byte at addr=0x41 -> 0x00000012.
- Back-pressure: memReqReady_i=0 for 10 cycles while pushing 6 stores.
  -> ldstReady_o=0 after 4 accepted with DEPTH=4 (first popped into REQ, so 5 accepted total).
  - Outputs stable during stall.
  - After release: 5 requests issued in order, addresses unchanged.
- Misaligned: word store at addr=0x102.
  -> misalign_o pulses once, no memReqValid_o.
  - A following aligned packet issues normally.
- Reset in WAIT: assert reset while waiting, then send memRspValid_i.
  -> no wbValid_o; FIFO empty; ldstReady_o=1.
